operand_fetch_ctrl: RTL and testbench
=====================================

Name: operand_fetch_ctrl

Overview:
Sequences the stage-1 operand fetch when RAM and input devices respond with variable latency rather than combinationally. On a start pulse it latches the operand mode (mblock_s1) and source byte (vr_source). It then issues a request to RAM or the input-device bus, waits for the acknowledge, and registers the fetched 32-bit value into vr_value. Constant operands complete without a bus request; illegal modes and timed-out requests are flagged with err.

Parameters:
TIMEOUT_CYCLES, 15, maximum number of cycles a request stays asserted without ack before abort (must be >= 1).
TIMER_W, 4, width of the wait counter (must satisfy 2^TIMER_W >= TIMEOUT_CYCLES).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  fetch request; sampled only in IDLE.
mblock_s1  input  2  operand mode: 0 = RAM, 2 = input device, 3 = constant, 1 = illegal.
vr_source  input  8  RAM address low byte / device address / constant value.
ram_req  output  1  RAM read request.
ram_address  output  16  RAM read address.
ram_ack  input  1  RAM data valid.
ram_value  input  32  RAM read data.
io_req  output  1  input-device read request.
input_devices_address  output  8  device address.
io_ack  input  1  device data valid.
input_devices_value  input  32  device read data.
vr_value  output  32  fetched operand, registered.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle completion pulse.
err  output  1  valid with done: illegal mode or timeout.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; vr_value = 0; ram_req, io_req, done, err, busy = 0; ram_address = 0; input_devices_address = 0; wait counter = 0. Requests drop immediately, including mid-wait. No fetch resumes after reset release.
- States: IDLE, RAM_WAIT, IO_WAIT, DONE.
- IDLE with start = 1 at a rising edge: latch mode and source.
  - mode 0 -> RAM_WAIT; ram_address = {8'h00, vr_source}.
  - mode 2 -> IO_WAIT; input_devices_address = vr_source.
  - mode 3 -> DONE; vr_value = {24'b0, vr_source}; err = 0.
  - mode 1 -> DONE; vr_value unchanged; err = 1.
- In both wait states the counter is cleared on entry.
- RAM_WAIT: ram_req = 1 (registered, asserted the cycle after start is sampled).
  - Edge with ram_ack = 1: vr_value <= ram_value; go to DONE with err = 0.
  - Edge with ram_ack = 0 and counter == TIMEOUT_CYCLES-1: go to DONE with err = 1; vr_value unchanged.
  - Otherwise the counter increments.
  - An ack on the final allowed cycle wins over the timeout.
- IO_WAIT: identical to RAM_WAIT using io_req, io_ack and input_devices_value.
- ram_req and io_req are never high simultaneously and are low outside their wait state. Addresses hold their last value after the request drops.
- DONE: done = 1 for exactly one cycle; busy = 1; err holds for that cycle. The next state is always IDLE; err clears on leaving DONE.
- start is ignored in every state except IDLE, including DONE. Back-to-back fetches therefore need start high in the IDLE cycle following done.
- ram_ack / io_ack are ignored outside their matching wait state.
- Latency from the start-sampling edge to the done-high cycle:
  - constant or illegal mode: 1 cycle.
  - RAM/IO with ack present in the first request cycle: 2 cycles.
  - timeout: TIMEOUT_CYCLES + 1 cycles.
- vr_value changes only on a successful capture or a constant fetch.

Test Plan:
- RAM fetch: ram_value = 55, vr_source = 33, mblock_s1 = 0, start pulse, ram_ack after 3 request cycles -> ram_address = 33 while ram_req = 1; done pulses once; vr_value = 55; err = 0; io_req stays 0.
- IO fetch: input_devices_value = 22, vr_source = 33, mblock_s1 = 2, io_ack in the first request cycle -> input_devices_address = 33; done 2 cycles after start; vr_value = 22.
- Constant and illegal modes: mblock_s1 = 3, vr_source = 33 -> done 1 cycle after start, vr_value = 33, no request asserted. Then mblock_s1 = 1 -> done with err = 1 and vr_value still 33.
- Timeout: mblock_s1 = 0, ram_ack held 0 -> ram_req high for exactly 15 cycles; done with err = 1; vr_value unchanged. Repeat with ack on the 15th cycle -> err = 0 and data captured.
- Reset mid-operation: assert reset_n = 0 during RAM_WAIT -> ram_req, busy and vr_value go to 0 without a clock edge. After release, the state is IDLE and a late ram_ack is ignored (no done).
- start held high continuously with mode 3 and vr_source incrementing -> one fetch every 2 cycles. start pulses during busy/DONE are ignored, and exactly one done is seen per accepted start.

Source files
------------

// File: rtl/operand_fetch_ctrl.sv
// Stage-1 operand fetch sequencer: issues a RAM or input-device read, waits for a
// variable-latency acknowledge with timeout, and registers the operand value.
module operand_fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMER_W        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mblock_s1,
    input  logic [7:0]  vr_source,
    output logic        ram_req,
    output logic [15:0] ram_address,
    input  logic        ram_ack,
    input  logic [31:0] ram_value,
    output logic        io_req,
    output logic [7:0]  input_devices_address,
    input  logic        io_ack,
    input  logic [31:0] input_devices_value,
    output logic [31:0] vr_value,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_WAIT,
        ST_IO_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_RAM   = 2'd0;
    localparam logic [1:0] MODE_IO    = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // Counter value on the last request cycle that may still accept an ack.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_ram_req;
    logic                r_io_req;
    logic [15:0]         r_ram_address;
    logic [7:0]          r_io_address;
    logic [31:0]         r_vr_value;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_ram_req     <= 1'b0;
            r_io_req      <= 1'b0;
            r_ram_address <= '0;
            r_io_address  <= '0;
            r_vr_value    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        case (mblock_s1)
                            MODE_RAM: begin
                                r_state       <= ST_RAM_WAIT;
                                r_ram_req     <= 1'b1;
                                r_ram_address <= {8'h00, vr_source};
                                r_timer       <= '0;
                            end
                            MODE_IO: begin
                                r_state      <= ST_IO_WAIT;
                                r_io_req     <= 1'b1;
                                r_io_address <= vr_source;
                                r_timer      <= '0;
                            end
                            MODE_CONST: begin
                                r_state    <= ST_DONE;
                                r_vr_value <= {24'b0, vr_source};
                                r_done     <= 1'b1;
                                r_err      <= 1'b0;
                            end
                            default: begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RAM_WAIT: begin
                    // Ack is checked before the timeout so a last-cycle ack still wins.
                    if (ram_ack) begin
                        r_vr_value <= ram_value;
                        r_ram_req  <= 1'b0;
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_err      <= 1'b0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_ram_req <= 1'b0;
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ack) begin
                        r_vr_value <= input_devices_value;
                        r_io_req   <= 1'b0;
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_err      <= 1'b0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_io_req <= 1'b0;
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_req               = r_ram_req;
    assign io_req                = r_io_req;
    assign ram_address           = r_ram_address;
    assign input_devices_address = r_io_address;
    assign vr_value              = r_vr_value;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign err                   = r_err;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_operand_fetch_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mblock_s1 = 2'd0;
    logic [7:0]  vr_source = 8'd0;
    logic        ram_req;
    logic [15:0] ram_address;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_value = 32'd0;
    logic        io_req;
    logic [7:0]  input_devices_address;
    logic        io_ack = 1'b0;
    logic [31:0] input_devices_value = 32'd0;
    logic [31:0] vr_value;
    logic        busy;
    logic        done;
    logic        err;

    operand_fetch_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .TIMER_W(4)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start                 (start),
        .mblock_s1             (mblock_s1),
        .vr_source             (vr_source),
        .ram_req               (ram_req),
        .ram_address           (ram_address),
        .ram_ack               (ram_ack),
        .ram_value             (ram_value),
        .io_req                (io_req),
        .input_devices_address (input_devices_address),
        .io_ack                (io_ack),
        .input_devices_value   (input_devices_value),
        .vr_value              (vr_value),
        .busy                  (busy),
        .done                  (done),
        .err                   (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, described by what the outside
    // world sees during the cycle that follows each clock edge.
    logic        m_busy = 0, m_done = 0, m_err = 0, m_ram_req = 0, m_io_req = 0;
    logic [15:0] m_ram_addr = 0;
    logic [7:0]  m_io_addr = 0;
    logic [31:0] m_vr = 0;
    int          m_reqs = 0;
    int          cnt_done = 0, cnt_ram = 0, cnt_io = 0;

    task automatic m_finish(input logic e);
        m_done = 1; m_err = e; m_ram_req = 0; m_io_req = 0;
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_ram_req = 0; m_io_req = 0;
            m_ram_addr = 0; m_io_addr = 0; m_vr = 0; m_reqs = 0;
        end else if (m_done) begin
            m_done = 0; m_err = 0; m_busy = 0;
        end else if (m_ram_req || m_io_req) begin
            m_reqs++;
            if (m_ram_req && ram_ack) begin
                m_vr = ram_value; m_finish(0);
            end else if (m_io_req && io_ack) begin
                m_vr = input_devices_value; m_finish(0);
            end else if (m_reqs == TIMEOUT) begin
                m_finish(1);
            end
        end else if (start) begin
            m_busy = 1;
            m_reqs = 0;
            case (mblock_s1)
                2'd0: begin m_ram_req = 1; m_ram_addr = {8'h00, vr_source}; end
                2'd2: begin m_io_req = 1; m_io_addr = vr_source; end
                2'd3: begin m_vr = {24'b0, vr_source}; m_done = 1; m_err = 0; end
                default: begin m_done = 1; m_err = 1; end
            endcase
        end
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("ram_req", 32'(ram_req), 32'(m_ram_req));
        check("io_req", 32'(io_req), 32'(m_io_req));
        check("ram_address", 32'(ram_address), 32'(m_ram_addr));
        check("io_address", 32'(input_devices_address), 32'(m_io_addr));
        check("vr_value", vr_value, m_vr);
        check("req_exclusive", 32'(ram_req & io_req), 32'd0);
        if (done) cnt_done++;
        if (ram_req) cnt_ram++;
        if (io_req) cnt_io++;
    end

    task automatic clear_counts();
        cnt_done = 0; cnt_ram = 0; cnt_io = 0;
    endtask

    // Starts a RAM fetch and raises ram_ack for the request cycle numbered ack_at
    // (0 = never). lat ends as the number of cycles until done was seen.
    task automatic run_ram(input logic [7:0] src, input int ack_at, output int lat);
        @(negedge clk);
        start = 1; mblock_s1 = 2'd0; vr_source = src;
        lat = 0;
        do begin
            @(negedge clk);
            start = 0;
            lat++;
            ram_ack = (lat == ack_at);
        end while (!done && lat < 40);
        ram_ack = 0;
    endtask

    int lat;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vr", vr_value, 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        reset_n = 1;
        @(negedge clk);

        // RAM fetch, ack after three request cycles
        clear_counts();
        ram_value = 32'd55;
        run_ram(8'd33, 3, lat);
        check("ram_lat", 32'(lat), 32'd4);
        check("ram_done", 32'(done), 32'd1);
        check("ram_vr", vr_value, 32'd55);
        check("ram_err", 32'(err), 32'd0);
        check("ram_addr_hold", 32'(ram_address), 32'd33);
        repeat (3) @(negedge clk);
        check("ram_done_cnt", 32'(cnt_done), 32'd1);
        check("ram_req_cnt", 32'(cnt_ram), 32'd3);
        check("ram_no_io", 32'(cnt_io), 32'd0);

        // IO fetch, ack in first request cycle (ack already high in IDLE is ignored)
        clear_counts();
        @(negedge clk);
        start = 1; mblock_s1 = 2'd2; vr_source = 8'd33;
        input_devices_value = 32'd22; io_ack = 1;
        @(negedge clk);
        start = 0;
        check("io_req_up", 32'(io_req), 32'd1);
        check("io_addr", 32'(input_devices_address), 32'd33);
        check("io_no_early_done", 32'(done), 32'd0);
        @(negedge clk);
        io_ack = 0;
        check("io_done", 32'(done), 32'd1);
        check("io_vr", vr_value, 32'd22);
        repeat (2) @(negedge clk);
        check("io_done_cnt", 32'(cnt_done), 32'd1);
        check("io_req_cnt", 32'(cnt_io), 32'd1);

        // Constant then illegal mode
        clear_counts();
        @(negedge clk);
        start = 1; mblock_s1 = 2'd3; vr_source = 8'd33;
        @(negedge clk);
        start = 0;
        check("const_done", 32'(done), 32'd1);
        check("const_vr", vr_value, 32'd33);
        check("const_err", 32'(err), 32'd0);
        @(negedge clk);
        start = 1; mblock_s1 = 2'd1; vr_source = 8'h77;
        @(negedge clk);
        start = 0;
        check("ill_done", 32'(done), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_vr", vr_value, 32'd33);
        @(negedge clk);
        check("ill_err_clear", 32'(err), 32'd0);
        check("const_no_req", 32'(cnt_ram + cnt_io), 32'd0);

        // Timeout without ack
        clear_counts();
        ram_value = 32'hDEADBEEF;
        run_ram(8'h10, 0, lat);
        check("to_lat", 32'(lat), 32'(TIMEOUT + 1));
        check("to_err", 32'(err), 32'd1);
        check("to_vr", vr_value, 32'd33);
        @(negedge clk);
        check("to_req_cnt", 32'(cnt_ram), 32'd15);

        // Ack on the final allowed request cycle
        clear_counts();
        run_ram(8'h11, TIMEOUT, lat);
        check("last_lat", 32'(lat), 32'(TIMEOUT + 1));
        check("last_err", 32'(err), 32'd0);
        check("last_vr", vr_value, 32'hDEADBEEF);
        @(negedge clk);
        check("last_req_cnt", 32'(cnt_ram), 32'd15);

        // Asynchronous reset during RAM_WAIT
        @(negedge clk);
        start = 1; mblock_s1 = 2'd0; vr_source = 8'h44;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        check("pre_rst_req", 32'(ram_req), 32'd1);
        #2;
        reset_n = 0;
        #1;
        check("arst_req", 32'(ram_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_vr", vr_value, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        clear_counts();
        ram_ack = 1;
        repeat (3) @(negedge clk);
        ram_ack = 0;
        check("late_ack_done", 32'(cnt_done), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);

        // start held high, constant mode, incrementing source
        clear_counts();
        @(negedge clk);
        start = 1; mblock_s1 = 2'd3; vr_source = 8'h80;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vr_source = vr_source + 8'd1;
        end
        start = 0;
        repeat (2) @(negedge clk);
        check("stream_done_cnt", 32'(cnt_done), 32'd5);
        check("stream_vr", vr_value, 32'h88);

        // start pulses while busy and during DONE are ignored
        clear_counts();
        ram_value = 32'h1234;
        @(negedge clk);
        start = 1; mblock_s1 = 2'd0; vr_source = 8'd5;
        @(negedge clk);
        mblock_s1 = 2'd3; vr_source = 8'd9;
        @(negedge clk);
        ram_ack = 1;
        @(negedge clk);
        ram_ack = 0;
        check("busy_ign_done", 32'(done), 32'd1);
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        check("busy_ign_cnt", 32'(cnt_done), 32'd1);
        check("busy_ign_vr", vr_value, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
